// File: rtl/final_video_pkg.sv
// ---------------------------------------------------------------------------
// final_video_pkg
//  Shared types and helpers for the layer priority mixer.
//  - layer_id_t   : storage type for one priority-table slot. It is sized for
//                   the largest supported layer count, so slots beyond the
//                   configured layer count simply hold the backdrop id.
//  - prio_table_t : MAX_LAYERS slots; slot 0 is the highest priority.
//  - lsel_w()     : width of a layer id, including the backdrop id.
//  - backdrop_id(): id reported when no layer is opaque.
//  - is_opaque()  : opacity test for one layer pixel.
// ---------------------------------------------------------------------------
package final_video_pkg;

   localparam int MAX_LAYERS = 8;
   localparam int LSEL_MAX   = 4;
   localparam int PIX_MAX    = 8;

   typedef logic [LSEL_MAX-1:0] layer_id_t;
   typedef layer_id_t prio_table_t [MAX_LAYERS];

   function automatic int lsel_w(input int num_layers);
      return $clog2(num_layers + 1);
   endfunction

   function automatic layer_id_t backdrop_id(input int num_layers);
      return layer_id_t'(num_layers);
   endfunction

   // A disabled layer is transparent whatever its pixel value.
   function automatic logic is_opaque(input logic en,
                                      input logic [PIX_MAX-1:0] pix,
                                      input logic [PIX_MAX-1:0] transp);
      return en && (pix != transp);
   endfunction

endpackage

// File: rtl/layer_prio_resolve.sv
// ---------------------------------------------------------------------------
// layer_prio_resolve
//  Combinational priority chain. Walks the table from slot 0 down and picks
//  the first opaque layer. A sprite-layer pixel holding the shadow index does
//  not win; it raises shadow and lets the search continue to lower slots.
//  Ports:
//   tbl     in   active priority table
//   opaque  in   per-layer opacity mask
//   spr_pix in   colour index of the sprite layer
//   winner  out  winning layer id, or the backdrop id
//   shadow  out  darken the resulting pixel
// ---------------------------------------------------------------------------
module layer_prio_resolve
   import final_video_pkg::*;
#(
   parameter int NUM_LAYERS = 3,
   parameter int PIX_W      = 3,
   parameter int SPR_LAYER  = 0,
   parameter int SHADOW_IDX = 6
) (
   input  prio_table_t             tbl,
   input  logic [NUM_LAYERS-1:0]   opaque,
   input  logic [PIX_W-1:0]        spr_pix,
   output layer_id_t               winner,
   output logic                    shadow
);

   logic                  found;
   logic [NUM_LAYERS-1:0] seen;

   // Ids that do not match any layer are skipped by construction, and the
   // seen mask makes a repeated id count only at its first slot.
   always_comb begin
      winner = backdrop_id(NUM_LAYERS);
      shadow = 1'b0;
      found  = 1'b0;
      seen   = '0;
      for (int s = 0; s < MAX_LAYERS; s++) begin
         for (int k = 0; k < NUM_LAYERS; k++) begin
            if (!found && !seen[k] && tbl[s] == layer_id_t'(k)) begin
               seen[k] = 1'b1;
               if (opaque[k]) begin
                  if (k == SPR_LAYER && spr_pix == PIX_W'(SHADOW_IDX)) begin
                     shadow = 1'b1;
                  end else begin
                     found  = 1'b1;
                     winner = layer_id_t'(k);
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/layer_prio_mixer.sv
// ---------------------------------------------------------------------------
// layer_prio_mixer
//  Merges NUM_LAYERS pixel streams through a double-buffered, CPU-written
//  priority table. Two pipeline stages gated by pix_ce: S1 registers the
//  pixel, bank and opacity mask; S2 resolves against the active table and
//  registers the palette address.
//  Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   pix_ce      pixel clock enable
//   vblank      vertical blank level; its rising edge swaps in the table
//   layer_pix   per-layer colour index, layer k at [k*PIX_W +: PIX_W]
//   layer_bank  per-layer colour bank, layer k at [k*BANK_W +: BANK_W]
//   layer_en    per-layer enable
//   prio_wr     load the pending table from prio_wdata
//   prio_wdata  slot s at [s*LSEL_W +: LSEL_W]; slot 0 highest priority
//   pal_addr    {layer_sel, bank, pix}
//   layer_sel   winning layer id; NUM_LAYERS means backdrop
//   shadow      darken the current pixel
//   out_valid   one-clock pulse per output update once the pipe is full
// ---------------------------------------------------------------------------
module layer_prio_mixer
   import final_video_pkg::*;
#(
   parameter int NUM_LAYERS    = 3,
   parameter int PIX_W         = 3,
   parameter int BANK_W        = 4,
   parameter int TRANSP_IDX    = 7,
   parameter int SPR_LAYER     = 0,
   parameter int SHADOW_IDX    = 6,
   parameter int BACKDROP_BANK = 0,
   parameter int LSEL_W        = lsel_w(NUM_LAYERS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           pix_ce,
   input  logic                           vblank,
   input  logic [NUM_LAYERS*PIX_W-1:0]    layer_pix,
   input  logic [NUM_LAYERS*BANK_W-1:0]   layer_bank,
   input  logic [NUM_LAYERS-1:0]          layer_en,
   input  logic                           prio_wr,
   input  logic [NUM_LAYERS*LSEL_W-1:0]   prio_wdata,
   output logic [LSEL_W+BANK_W+PIX_W-1:0] pal_addr,
   output logic [LSEL_W-1:0]              layer_sel,
   output logic                           shadow,
   output logic                           out_valid
);

   localparam logic [LSEL_W+BANK_W+PIX_W-1:0] BACKDROP_ADDR =
      {LSEL_W'(NUM_LAYERS), BANK_W'(BACKDROP_BANK), PIX_W'(0)};

   prio_table_t                 pend_tbl;
   prio_table_t                 act_tbl;
   prio_table_t                 wr_tbl;
   prio_table_t                 ident_tbl;
   logic                        vblank_d;
   logic                        vblank_rise;

   logic [NUM_LAYERS*PIX_W-1:0]  s1_pix;
   logic [NUM_LAYERS*BANK_W-1:0] s1_bank;
   logic [NUM_LAYERS-1:0]        s1_opaque;
   logic [NUM_LAYERS-1:0]        cur_opaque;
   logic [1:0]                   fill_cnt;

   layer_id_t                    res_winner;
   logic                         res_shadow;
   logic [BANK_W-1:0]            next_bank;
   logic [PIX_W-1:0]             next_pix;

   assign vblank_rise = vblank & ~vblank_d;

   // Unpack the CPU write word and build the identity table. Slots past the
   // configured layer count hold the backdrop id so the resolver ignores them.
   always_comb begin
      for (int s = 0; s < MAX_LAYERS; s++) begin
         wr_tbl[s]    = backdrop_id(NUM_LAYERS);
         ident_tbl[s] = backdrop_id(NUM_LAYERS);
      end
      for (int s = 0; s < NUM_LAYERS; s++) begin
         wr_tbl[s]    = layer_id_t'(prio_wdata[s*LSEL_W +: LSEL_W]);
         ident_tbl[s] = layer_id_t'(s);
      end
   end

   // Table buffers run every clock, independent of pix_ce. A write landing
   // on the vblank rise goes straight to the active table as well.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_tbl <= ident_tbl;
         act_tbl  <= ident_tbl;
         vblank_d <= 1'b0;
      end else begin
         vblank_d <= vblank;
         if (prio_wr) begin
            pend_tbl <= wr_tbl;
         end
         if (vblank_rise) begin
            act_tbl <= prio_wr ? wr_tbl : pend_tbl;
         end
      end
   end

   always_comb begin
      cur_opaque = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         cur_opaque[k] = is_opaque(layer_en[k],
                                   PIX_MAX'(layer_pix[k*PIX_W +: PIX_W]),
                                   PIX_MAX'(TRANSP_IDX));
      end
   end

   layer_prio_resolve #(
      .NUM_LAYERS (NUM_LAYERS),
      .PIX_W      (PIX_W),
      .SPR_LAYER  (SPR_LAYER),
      .SHADOW_IDX (SHADOW_IDX)
   ) u_resolve (
      .tbl     (act_tbl),
      .opaque  (s1_opaque),
      .spr_pix (s1_pix[SPR_LAYER*PIX_W +: PIX_W]),
      .winner  (res_winner),
      .shadow  (res_shadow)
   );

   // Pick bank and index of the winner; the backdrop keeps its fixed bank.
   always_comb begin
      next_bank = BANK_W'(BACKDROP_BANK);
      next_pix  = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         if (res_winner == layer_id_t'(k)) begin
            next_bank = s1_bank[k*BANK_W +: BANK_W];
            next_pix  = s1_pix[k*PIX_W +: PIX_W];
         end
      end
   end

   // out_valid looks at the count before this update, so it first pulses on
   // the third pix_ce after reset and is low on any clock without pix_ce.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_pix    <= '0;
         s1_bank   <= '0;
         s1_opaque <= '0;
         pal_addr  <= BACKDROP_ADDR;
         layer_sel <= LSEL_W'(NUM_LAYERS);
         shadow    <= 1'b0;
         out_valid <= 1'b0;
         fill_cnt  <= 2'd0;
      end else begin
         out_valid <= pix_ce && (fill_cnt == 2'd2);
         if (pix_ce) begin
            s1_pix    <= layer_pix;
            s1_bank   <= layer_bank;
            s1_opaque <= cur_opaque;
            layer_sel <= LSEL_W'(res_winner);
            pal_addr  <= {LSEL_W'(res_winner), next_bank, next_pix};
            shadow    <= res_shadow;
            if (fill_cnt != 2'd2) begin
               fill_cnt <= fill_cnt + 2'd1;
            end
         end
      end
   end

endmodule
